// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush, and an optional 2-entry skid.
// Bubbles always present all-zero control; the data field holds its last value.
module pipe_stage_reg #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 101,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_accept;
  logic              w_emit;
  logic              w_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept  = in_valid && in_ready;
  assign w_emit    = w_valid && out_ready;
  assign out_valid = w_valid;
  assign out_ctrl  = w_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
      state_t            r_state;
      state_t            w_state_nxt;
      logic              r_in_ready;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              w_load_main_in;
      logic              w_load_main_skid;
      logic              w_load_skid;

      assign in_ready = r_in_ready;
      assign w_valid  = (r_state != EMPTY);

      always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
          EMPTY: if (w_accept) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
          ONE: begin
            if (w_accept && w_emit) begin
              w_load_main_in = 1'b1;
            end else if (w_accept) begin
              w_state_nxt = TWO;
              w_load_skid = 1'b1;
            end else if (w_emit) begin
              w_state_nxt = EMPTY;
            end
          end
          TWO: if (w_emit) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
          default: w_state_nxt = EMPTY;
        endcase
        // Flush drops everything, including a word accepted this cycle.
        if (flush) begin
          w_state_nxt      = EMPTY;
          w_load_main_in   = 1'b0;
          w_load_main_skid = 1'b0;
          w_load_skid      = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_main_ctrl <= '0;
          r_main_data <= '0;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          r_state    <= w_state_nxt;
          r_in_ready <= (w_state_nxt != TWO);
          if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
          end
          if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end
        end
      end
    end else begin : g_single
      logic r_valid;

      assign w_valid  = r_valid;
      assign in_ready = !r_valid || out_ready;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid     <= 1'b0;
          r_main_ctrl <= '0;
          r_main_data <= '0;
        end else begin
          if (flush)         r_valid <= 1'b0;
          else if (w_accept) r_valid <= 1'b1;
          else if (w_emit)   r_valid <= 1'b0;
          if (w_accept && !flush) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end
        end
      end
    end
  endgenerate

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_valid && !out_ready && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, single entry, 4-bit counter) tracked every cycle
// by a FIFO-occupancy model, plus directed vector tables and corner-case sequences.
module tb_pipe_stage_reg;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        rst, fl, iv, ordy, ir, ov;
  logic [N-1:0][5:0]   ic, oc;
  logic [N-1:0][100:0] id, od;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  pipe_stage_reg #(.SKID(1)) u_a (
    .clk(clk), .reset(rst[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_ctrl(ic[0]), .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc0));
  pipe_stage_reg #(.SKID(0)) u_b (
    .clk(clk), .reset(rst[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_ctrl(ic[1]), .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc1));
  pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(rst[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_ctrl(ic[2]), .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc2));

  int checks = 0;
  int failures = 0;

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single), front word on the outputs.
  typedef struct packed { logic [5:0] c; logic [100:0] d; } word_t;
  word_t        mbuf[N][2];
  int           mn[N];
  int           mcnt[N];
  logic [100:0] mlast[N];
  bit           mvalid[N];
  int           cmax[N] = '{65535, 65535, 15};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic mir(int k);
    return (k == 1) ? (mn[k] == 0 || ordy[k]) : (mn[k] < 2);
  endfunction

  function automatic int get_sc(int k);
    return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
  endfunction

  task automatic setin(input int k, input logic v, input logic [5:0] c, input logic [100:0] d,
                       input logic r);
    iv[k] = v; ic[k] = c; id[k] = d; ordy[k] = r;
  endtask

  // Check all instances against the model, advance the model, then cross one clock edge.
  task automatic tick();
    bit acc, em;
    for (int k = 0; k < N; k++) begin
      if (mvalid[k]) begin
        chk($sformatf("m%0d out_valid", k), ov[k], mn[k] > 0);
        chk($sformatf("m%0d out_ctrl", k), oc[k], (mn[k] > 0) ? mbuf[k][0].c : 6'h0);
        chk($sformatf("m%0d out_data", k), od[k], (mn[k] > 0) ? mbuf[k][0].d : mlast[k]);
        chk($sformatf("m%0d in_ready", k), ir[k], mir(k));
        chk($sformatf("m%0d stall_cnt", k), get_sc(k), mcnt[k]);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rst[k]) begin
        mn[k] = 0; mlast[k] = '0; mcnt[k] = 0; mvalid[k] = 1'b1;
      end else if (mvalid[k]) begin
        acc = iv[k] && mir(k);
        em  = (mn[k] > 0) && ordy[k];
        if (mn[k] > 0 && !ordy[k] && mcnt[k] < cmax[k]) mcnt[k]++;
        if (em) begin mbuf[k][0] = mbuf[k][1]; mn[k]--; end
        if (fl[k]) mn[k] = 0;
        else if (acc) begin mbuf[k][mn[k]] = {ic[k], id[k]}; mn[k]++; end
        if (mn[k] > 0) mlast[k] = mbuf[k][0].d;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [5:0] c; logic [100:0] d; logic r;
    logic e_ov; logic [5:0] e_oc; logic [100:0] e_od; logic e_ir;
  } vec_t;
  vec_t tv[12];

  initial begin
    int nxt, exp_out;
    logic [127:0] t;
    for (int i = 0; i < 12; i++) begin
      tv[i].v    = (i < 10);
      tv[i].c    = 6'h2D;
      tv[i].d    = 101'(i);
      tv[i].r    = 1'b1;
      tv[i].e_ov = (i >= 1 && i <= 10);
      tv[i].e_oc = tv[i].e_ov ? 6'h2D : 6'h0;
      tv[i].e_od = (i == 0) ? 101'd0 : (i <= 10) ? 101'(i - 1) : 101'd9;
      tv[i].e_ir = 1'b1;
    end

    rst = '1; fl = '0; iv = '0; ordy = '1; ic = '0; id = '0;
    @(negedge clk);
    tick();
    rst = '0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst%0d out_valid", k), ov[k], 1'b0);
      chk($sformatf("rst%0d out_ctrl", k), oc[k], 6'h0);
      chk($sformatf("rst%0d out_data", k), od[k], 101'd0);
      chk($sformatf("rst%0d stall_cnt", k), get_sc(k), 0);
      chk($sformatf("rst%0d in_ready", k), ir[k], 1'b1);
    end
    tick();

    // Streaming at full rate through the skid stage
    for (int i = 0; i < 12; i++) begin
      setin(0, tv[i].v, tv[i].c, tv[i].d, tv[i].r);
      #1;
      chk($sformatf("stream%0d out_valid", i), ov[0], tv[i].e_ov);
      chk($sformatf("stream%0d out_ctrl", i), oc[0], tv[i].e_oc);
      chk($sformatf("stream%0d out_data", i), od[0], tv[i].e_od);
      chk($sformatf("stream%0d in_ready", i), ir[0], tv[i].e_ir);
      tick();
    end

    // Back-pressure: A held, B in skid, C held upstream
    setin(0, 1, 6'h2D, 101'd100, 1); #1; tick();
    setin(0, 1, 6'h2D, 101'd101, 0); #1; chk("bp A on out", od[0], 101'd100); tick();
    setin(0, 1, 6'h2D, 101'd102, 0); #1;
    chk("bp in_ready low", ir[0], 1'b0);
    chk("bp A held", od[0], 101'd100);
    tick(); tick(); tick();
    setin(0, 1, 6'h2D, 101'd102, 1); #1;
    chk("bp stall_cnt", sc0, 16'd4);
    tick();
    #1;
    chk("bp B out", od[0], 101'd101);
    chk("bp in_ready back", ir[0], 1'b1);
    tick();
    setin(0, 0, 6'h0, 101'd0, 1); #1;
    chk("bp C out", od[0], 101'd102);
    chk("bp C valid", ov[0], 1'b1);
    tick();
    #1;
    chk("bp drained valid", ov[0], 1'b0);
    chk("bp drained ctrl", oc[0], 6'h0);
    tick();

    // Flush while full, with D offered
    setin(0, 1, 6'h2D, 101'd200, 0); #1; tick();
    setin(0, 1, 6'h2D, 101'd201, 0); #1; tick();
    setin(0, 1, 6'h2D, 101'd202, 0); fl[0] = 1'b1; #1;
    chk("fl full in_ready", ir[0], 1'b0);
    tick();
    fl[0] = 1'b0; setin(0, 0, 6'h0, 101'd0, 1); #1;
    chk("fl out_valid", ov[0], 1'b0);
    chk("fl out_ctrl", oc[0], 6'h0);
    chk("fl in_ready", ir[0], 1'b1);
    chk("fl data kept", od[0], 101'd200);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1; chk("fl D never out", ov[0], 1'b0); tick();
    end

    // Reset while full with stall_cnt=5
    rst[0] = 1'b1; #1; tick(); rst[0] = 1'b0;
    setin(0, 1, 6'h2D, 101'd300, 0); #1; tick();
    setin(0, 1, 6'h2D, 101'd301, 0); #1; tick();
    setin(0, 0, 6'h0, 101'd0, 0);
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    #1;
    chk("rs pre stall_cnt", sc0, 16'd5);
    chk("rs pre full", ir[0], 1'b0);
    rst[0] = 1'b1; fl[0] = 1'b1; setin(0, 1, 6'h3F, 101'd999, 1); #1; tick();
    rst[0] = 1'b0; fl[0] = 1'b0; setin(0, 0, 6'h0, 101'd0, 1); #1;
    chk("rs out_valid", ov[0], 1'b0);
    chk("rs out_ctrl", oc[0], 6'h0);
    chk("rs out_data", od[0], 101'd0);
    chk("rs stall_cnt", sc0, 16'd0);
    chk("rs in_ready", ir[0], 1'b1);
    tick();

    // Single-entry stage with alternating out_ready: in-order, no loss or duplication
    nxt = 500; exp_out = 500;
    for (int i = 0; i < 28; i++) begin
      if (i < 24) setin(1, 1, 6'h15, 101'(nxt), i[0]);
      else        setin(1, 0, 6'h0, 101'd0, 1);
      #1;
      chk("s0 in_ready comb", ir[1], !ov[1] || ordy[1]);
      if (ov[1] && ordy[1]) begin
        chk("s0 order", od[1], 101'(exp_out));
        exp_out++;
      end
      if (iv[1] && ir[1]) nxt++;
      tick();
    end
    chk("s0 all delivered", exp_out, nxt);

    // Counter saturation at 15 with CNT_W=4
    setin(2, 1, 6'h2D, 101'd77, 0); #1; tick();
    setin(2, 0, 6'h0, 101'd0, 0);
    for (int i = 0; i < 20; i++) begin #1; tick(); end
    #1;
    chk("sat stall_cnt", sc2, 4'd15);
    chk("sat still valid", ov[2], 1'b1);
    setin(2, 0, 6'h0, 101'd0, 1); #1; tick();

    // Random traffic on the skid and single-entry stages
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]  = ($urandom % 97) == 0;
        fl[k]   = ($urandom % 13) == 0;
        iv[k]   = ($urandom % 4) != 0;
        ordy[k] = ($urandom % 3) != 0;
        ic[k]   = 6'($urandom);
        t = {$urandom, $urandom, $urandom, $urandom};
        id[k]   = t[100:0];
      end
      #1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
